// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button debouncer and related pin-input blocks.
package btn_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HIGH,
    S_HIGH,
    S_WAIT_LOW
  } btn_state_t;

  localparam int DEFAULT_STABLE_CYCLES = 1000000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous pin levels into the clock domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronizes a bouncing pin, accepts a level only after it has
// been stable long enough, and emits rise/fall strobes plus a wrapping press counter.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int PCNT_W        = 8
) (
  input  logic              CLK100MHZ,
  input  logic              RST,
  input  logic              BTN_IN,
  output logic              BTN_LEVEL,
  output logic              BTN_RISE,
  output logic              BTN_FALL,
  output logic [PCNT_W-1:0] PRESS_CNT
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic              btn_s;
  btn_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              level_q;
  logic              rise_q;
  logic              fall_q;
  logic [PCNT_W-1:0] press_q;

  sync_2ff #(
    .WIDTH(1)
  ) u_sync (
    .clk_i(CLK100MHZ),
    .rst_i(RST),
    .d_i  (BTN_IN),
    .q_o  (btn_s)
  );

  // Strobes default low every cycle so they can only ever last one clock.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      press_q <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        S_LOW: begin
          if (btn_s) begin
            state_q <= S_WAIT_HIGH;
            cnt_q   <= '0;
          end
        end
        S_WAIT_HIGH: begin
          if (!btn_s) begin
            state_q <= S_LOW;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_HIGH;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
            press_q <= press_q + PCNT_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (!btn_s) begin
            state_q <= S_WAIT_LOW;
            cnt_q   <= '0;
          end
        end
        S_WAIT_LOW: begin
          if (btn_s) begin
            state_q <= S_HIGH;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_LOW;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign BTN_LEVEL = level_q;
  assign BTN_RISE  = rise_q;
  assign BTN_FALL  = fall_q;
  assign PRESS_CNT = press_q;

endmodule
